// File: rtl/net_top.sv
// Audio-over-UDP bridge: packs periodic FIFO samples into fixed-size UDP payloads and
// unpacks received payload bytes (MSB first) into 16-bit samples for a downstream FIFO.
module net_top #(
  parameter int unsigned SAMPLE_DIV      = 1088,
  parameter int unsigned SAMPLES_PER_PKT = 60
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  wav_out_data,
  output logic                         wav_rden,
  output logic [15:0]                  wav_in_data,
  output logic                         wav_wren,
  output logic                         udp_send_data_valid,
  input  logic                         udp_send_data_ready,
  output logic [16*SAMPLES_PER_PKT:0]  udp_send_data,
  output logic [15:0]                  udp_send_data_length,
  input  logic                         udp_rec_data_valid,
  input  logic [7:0]                   udp_rec_rdata,
  input  logic [15:0]                  udp_rec_data_length
);

  localparam int unsigned PayW  = 16 * SAMPLES_PER_PKT;
  localparam int unsigned TickW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CntW  = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;

  // Transmit path state
  logic [TickW-1:0] tick_q, tick_d;
  logic             rd_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PayW-1:0]  asm_q, asm_d;
  logic [PayW-1:0]  pend_q, pend_d;
  logic             valid_q, valid_d;
  logic [PayW-1:0]  asm_next;
  logic             pkt_done;

  // Receive path state
  logic [15:0] idx_q, idx_d;
  logic [7:0]  msb_q, msb_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wren_q, wren_d;

  assign wav_rden             = (tick_q == TickW'(SAMPLE_DIV - 1));
  // Shifting left places the first sample of a packet in the top 16 bits after the last shift.
  assign asm_next             = {asm_q[PayW-17:0], wav_out_data};
  assign pkt_done             = rd_q && (cnt_q == CntW'(SAMPLES_PER_PKT - 1));
  assign udp_send_data        = {1'b0, pend_q};
  assign udp_send_data_valid  = valid_q;
  assign udp_send_data_length = 16'(2 * SAMPLES_PER_PKT);
  assign wav_in_data          = wdata_q;
  assign wav_wren             = wren_q;

  always_comb begin
    tick_d  = wav_rden ? '0 : tick_q + TickW'(1);
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    if (valid_q && udp_send_data_ready) begin
      valid_d = 1'b0;
    end
    if (rd_q) begin
      asm_d = asm_next;
      cnt_d = pkt_done ? '0 : cnt_q + CntW'(1);
    end
    // A completing packet always wins: it replaces any unaccepted one and keeps valid up.
    if (pkt_done) begin
      pend_d  = asm_next;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    msb_d   = msb_q;
    wdata_d = wdata_q;
    wren_d  = 1'b0;
    if (udp_rec_data_valid) begin
      if (udp_rec_data_length == 16'd0) begin
        idx_d = '0;
      end else begin
        if (!idx_q[0]) begin
          msb_d = udp_rec_rdata;
        end else begin
          wdata_d = {msb_q, udp_rec_rdata};
          wren_d  = 1'b1;
        end
        idx_d = (idx_q == udp_rec_data_length - 16'd1) ? '0 : idx_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q  <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      asm_q   <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      msb_q   <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      rd_q    <= wav_rden;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      msb_q   <= msb_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
    end
  end

endmodule

// File: tb/tb_net_top.sv
// Directed bench for net_top with a shortened sample period; upstream FIFO returns its read index.
module tb_net_top;

  localparam int unsigned Div = 8;
  localparam int unsigned Spp = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  wav_out_data;
  logic         wav_rden;
  logic [15:0]  wav_in_data;
  logic         wav_wren;
  logic         udp_send_data_valid;
  logic         udp_send_data_ready = 1'b1;
  logic [960:0] udp_send_data;
  logic [15:0]  udp_send_data_length;
  logic         udp_rec_data_valid = 1'b0;
  logic [7:0]   udp_rec_rdata = 8'h00;
  logic [15:0]  udp_rec_data_length = 16'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_n = 0;
  int wr_n = 0;
  logic [15:0] wr_data [0:63];
  logic [15:0] sidx;

  net_top #(.SAMPLE_DIV(Div), .SAMPLES_PER_PKT(Spp)) u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .wav_out_data         (wav_out_data),
    .wav_rden             (wav_rden),
    .wav_in_data          (wav_in_data),
    .wav_wren             (wav_wren),
    .udp_send_data_valid  (udp_send_data_valid),
    .udp_send_data_ready  (udp_send_data_ready),
    .udp_send_data        (udp_send_data),
    .udp_send_data_length (udp_send_data_length),
    .udp_rec_data_valid   (udp_rec_data_valid),
    .udp_rec_rdata        (udp_rec_rdata),
    .udp_rec_data_length  (udp_rec_data_length)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data valid one cycle after the read strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sidx         <= 16'd0;
      wav_out_data <= 16'd0;
    end else if (wav_rden) begin
      wav_out_data <= sidx;
      sidx         <= sidx + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (wav_rden) rd_n++;
    if (wav_wren && wr_n < 64) begin
      wr_data[wr_n] = wav_in_data;
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!udp_send_data_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!udp_send_data_valid) check(tag, 32'(udp_send_data_valid), 32'd1);
  endtask

  task automatic rden_latency(input string tag);
    int n = 0;
    while (!wav_rden && n < 4 * Div) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n), 32'(Div - 1));
  endtask

  task automatic rx_byte(input logic [7:0] b);
    udp_rec_data_valid = 1'b1;
    udp_rec_rdata      = b;
    @(negedge clk);
    udp_rec_data_valid = 1'b0;
  endtask

  initial begin
    int base;
    int dropped;
    int n;

    // Reset state
    #12;
    check("rst_valid", 32'(udp_send_data_valid), 32'd0);
    check("rst_rden", 32'(wav_rden), 32'd0);
    check("rst_wren", 32'(wav_wren), 32'd0);
    check("rst_wdata", 32'(wav_in_data), 32'd0);
    check("rst_data_lo", 32'(udp_send_data[31:0]), 32'd0);
    check("rst_length", 32'(udp_send_data_length), 32'd120);
    @(negedge clk);
    rst_n = 1'b1;

    // First packet, with a receive packet overlapping the handshake
    base = wr_n;
    fork
      begin
        rden_latency("first_rden");
        wait_valid("pkt1_timeout", Spp * Div + 40);
        check("pkt1_first", 32'(udp_send_data[959:944]), 32'h0000);
        check("pkt1_mid", 32'(udp_send_data[479:464]), 32'd30);
        check("pkt1_last", 32'(udp_send_data[15:0]), 32'h003B);
        check("pkt1_bit960", 32'(udp_send_data[960]), 32'd0);
        check("pkt1_length", 32'(udp_send_data_length), 32'd120);
        @(negedge clk);
        check("pkt1_drop", 32'(udp_send_data_valid), 32'd0);
      end
      begin
        repeat (478) @(negedge clk);
        udp_rec_data_length = 16'd4;
        rx_byte(8'h12);
        rx_byte(8'h34);
        rx_byte(8'hAB);
        rx_byte(8'hCD);
      end
    join
    repeat (3) @(negedge clk);
    check("rx4_count", 32'(wr_n - base), 32'd2);
    check("rx4_w0", 32'(wr_data[base]), 32'h1234);
    check("rx4_w1", 32'(wr_data[base+1]), 32'hABCD);
    check("rx4_hold", 32'(wav_in_data), 32'hABCD);
    check("rd_count", 32'(rd_n >= 60), 32'd1);

    // Two completions while not ready: newest overwrites, valid held
    udp_send_data_ready = 1'b0;
    wait_valid("pkt2_timeout", Spp * Div + 40);
    check("pkt2_first", 32'(udp_send_data[959:944]), 32'd60);
    check("pkt2_last", 32'(udp_send_data[15:0]), 32'd119);
    dropped = 0;
    n = 0;
    while (udp_send_data[15:0] != 16'd179 && n < Spp * Div + 40) begin
      @(negedge clk);
      if (!udp_send_data_valid) dropped = 1;
      n++;
    end
    check("hold_valid", 32'(dropped), 32'd0);
    check("pkt3_valid", 32'(udp_send_data_valid), 32'd1);
    check("pkt3_first", 32'(udp_send_data[959:944]), 32'd120);
    check("pkt3_last", 32'(udp_send_data[15:0]), 32'd179);
    udp_send_data_ready = 1'b1;
    @(negedge clk);
    check("pkt3_drop", 32'(udp_send_data_valid), 32'd0);

    // Odd-length packet drops its tail byte; zero-length bytes ignored
    base = wr_n;
    udp_rec_data_length = 16'd3;
    rx_byte(8'h01);
    rx_byte(8'h02);
    rx_byte(8'h03);
    udp_rec_data_length = 16'd2;
    rx_byte(8'h55);
    rx_byte(8'h66);
    udp_rec_data_length = 16'd0;
    rx_byte(8'hEE);
    rx_byte(8'hFF);
    rx_byte(8'hDD);
    udp_rec_data_length = 16'd2;
    rx_byte(8'hA5);
    rx_byte(8'h5A);
    repeat (3) @(negedge clk);
    check("rxodd_count", 32'(wr_n - base), 32'd3);
    check("rxodd_w0", 32'(wr_data[base]), 32'h0102);
    check("rxodd_w1", 32'(wr_data[base+1]), 32'h5566);
    check("rxlen0_w", 32'(wr_data[base+2]), 32'hA55A);

    // Reset mid-packet on both paths
    base = rd_n;
    n = 0;
    while (rd_n < base + 30 && n < 40 * Div) begin
      @(negedge clk);
      n++;
    end
    check("mid_reads", 32'(rd_n - base), 32'd30);
    rx_byte(8'h77);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(udp_send_data_valid), 32'd0);
    check("mid_rst_rden", 32'(wav_rden), 32'd0);
    check("mid_rst_wren", 32'(wav_wren), 32'd0);
    check("mid_rst_wdata", 32'(wav_in_data), 32'd0);
    check("mid_rst_data", 32'(udp_send_data[959:928]), 32'd0);
    check("mid_rst_length", 32'(udp_send_data_length), 32'd120);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_n;
    rden_latency("post_rst_rden");
    rx_byte(8'h9A);
    rx_byte(8'hBC);
    repeat (2) @(negedge clk);
    check("post_rst_rx_count", 32'(wr_n - base), 32'd1);
    check("post_rst_rx", 32'(wr_data[base]), 32'h9ABC);
    wait_valid("pkt4_timeout", Spp * Div + 40);
    check("pkt4_first", 32'(udp_send_data[959:944]), 32'h0000);
    check("pkt4_last", 32'(udp_send_data[15:0]), 32'h003B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
